// File: rtl/stream_upsize_arb.sv
// Packet-level round-robin arbiter feeding one stream_upsize slave port from N_SRC sources.
// Define STREAM_UPSIZE_ARB_ID_EN to expose m_src_o, the index of the source driving m.
module stream_upsize_arb #(
    parameter int  N_SRC        = 4,
    parameter int  T_DATA_WIDTH = 4,
    localparam int SRC_W        = $clog2(N_SRC)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_SRC-1:0][T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [N_SRC-1:0]                     s_last_i,
    input  logic [N_SRC-1:0]                     s_valid_i,
    output logic [N_SRC-1:0]                     s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
`ifdef STREAM_UPSIZE_ARB_ID_EN
    output logic [SRC_W-1:0]                     m_src_o,
`endif
    output logic                                 busy_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [SRC_W-1:0] rr_last_q, rr_last_d;
    logic [SRC_W-1:0] sel;
    logic [SRC_W-1:0] idx;
    logic             found;
    logic             sel_vld;
    logic             acc;

    // While idle, search starts just after the last packet winner so every requester gets a turn.
    always_comb begin
        sel   = owner_q;
        found = 1'b0;
        idx   = '0;
        if (state_q == IDLE) begin
            sel = '0;
            for (int i = 1; i <= N_SRC; i++) begin
                idx = SRC_W'((int'(rr_last_q) + i) % N_SRC);
                if (!found && s_valid_i[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end
        sel_vld = rst_n && ((state_q == LOCKED) || found);
    end

    always_comb begin
        m_data_o  = s_data_i[sel];
        m_last_o  = s_last_i[sel];
        m_valid_o = sel_vld && s_valid_i[sel];
        s_ready_o = '0;
        if (sel_vld) begin
            s_ready_o[sel] = m_ready_i;
        end
        acc = m_valid_o && m_ready_i;
    end

    // A stalled first beat also locks, so a late higher-priority request cannot change m_data_o.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        if (state_q == IDLE) begin
            if (m_valid_o) begin
                if (m_ready_i && m_last_o) begin
                    rr_last_d = sel;
                end else begin
                    state_d = LOCKED;
                    owner_d = sel;
                end
            end
        end else if (acc && m_last_o) begin
            state_d   = IDLE;
            rr_last_d = owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_last_q <= SRC_W'(N_SRC - 1);
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign busy_o = (state_q == LOCKED);

`ifdef STREAM_UPSIZE_ARB_ID_EN
    assign m_src_o = sel_vld ? sel : '0;
`endif

endmodule

// File: tb/tb_stream_upsize_arb.sv
// Randomized scoreboard bench for stream_upsize_arb: per-source beat queues plus a packet-level
// round-robin model decide which source must own the output and which beat it must present.
module tb_stream_upsize_arb;
    localparam int N = 4;
    localparam int W = 4;

    typedef logic [W:0] beat_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0][W-1:0] s_data_i;
    logic [N-1:0]        s_last_i;
    logic [N-1:0]        s_valid_i;
    logic [N-1:0]        s_ready_o;
    logic [W-1:0]        m_data_o;
    logic                m_last_o;
    logic                m_valid_o;
    logic                m_ready_i;
    logic                busy_o;
`ifdef STREAM_UPSIZE_ARB_ID_EN
    logic [1:0]          m_src_o;
`endif

    always #5 clk = ~clk;

    stream_upsize_arb #(.N_SRC(N), .T_DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
`ifdef STREAM_UPSIZE_ARB_ID_EN
        .m_src_o   (m_src_o),
`endif
        .busy_o    (busy_o)
    );

    beat_t stim_q[N][$];
    beat_t exp_q[N][$];
    int    vprob[N];
    int    rprob;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int s, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), W'($urandom)};
            stim_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
    endtask

    function automatic int pending();
        int left = 0;
        for (int s = 0; s < N; s++) left += stim_q[s].size() + exp_q[s].size();
        return left;
    endfunction

    task automatic drain(input int budget);
        for (int c = 0; c < budget && pending() != 0; c++) begin
            @(posedge clk); #3;
        end
        chk("drain", 32'(pending()), 32'd0);
    endtask

    // Source drivers: a presented beat stays valid and stable until it is accepted.
    initial begin : driver
        logic [N-1:0] acc;
        s_valid_i = '0;
        s_last_i  = '0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            acc = s_valid_i & s_ready_o;
            @(posedge clk); #1;
            for (int s = 0; s < N; s++) begin
                if (!rst_n) begin
                    s_valid_i[s] = 1'b0;
                end else begin
                    if (acc[s] && stim_q[s].size() > 0) void'(stim_q[s].pop_front());
                    if (stim_q[s].size() == 0) s_valid_i[s] = 1'b0;
                    else if (!(s_valid_i[s] && !acc[s]))
                        s_valid_i[s] = ($urandom_range(99) < vprob[s]);
                    if (stim_q[s].size() > 0) {s_last_i[s], s_data_i[s]} = stim_q[s][0];
                end
            end
            m_ready_i = ($urandom_range(99) < rprob);
        end
    end

    // Reference: a free output goes to the first requester after the previous winner and stays
    // with it until its last beat is accepted; busy reflects a packet carried over from a prior cycle.
    bit    in_pkt = 1'b0;
    int    cur = 0;
    int    last_win = N - 1;
    int    c;
    beat_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_pkt   = 1'b0;
            cur      = 0;
            last_win = N - 1;
        end else begin
            chk("busy", 32'(busy_o), 32'(in_pkt));
            if (!in_pkt && s_valid_i != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (last_win + k) % N;
                    if (!in_pkt && s_valid_i[c]) begin
                        in_pkt = 1'b1;
                        cur    = c;
                    end
                end
            end
            if (!in_pkt) begin
                chk("idle_m_valid", 32'(m_valid_o), 32'd0);
                chk("idle_s_ready", 32'(s_ready_o), 32'd0);
            end else begin
                chk("m_valid", 32'(m_valid_o), 32'(s_valid_i[cur]));
                chk("s_ready", 32'(s_ready_o), m_ready_i ? (32'd1 << cur) : 32'd0);
                if (s_valid_i[cur]) begin
`ifdef STREAM_UPSIZE_ARB_ID_EN
                    chk("m_src", 32'(m_src_o), 32'(cur));
`endif
                    chk("beat_pending", 32'(exp_q[cur].size() > 0), 32'd1);
                    if (exp_q[cur].size() > 0) begin
                        e = exp_q[cur][0];
                        chk("m_beat", 32'({m_last_o, m_data_o}), 32'(e));
                        if (m_ready_i) begin
                            void'(exp_q[cur].pop_front());
                            if (e[W]) begin
                                in_pkt   = 1'b0;
                                last_win = cur;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic set_all(input int vp, input int rp);
        for (int s = 0; s < N; s++) vprob[s] = vp;
        rprob = rp;
    endtask

    initial begin : main
        set_all(100, 100);
        rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // two simultaneous 3-beat packets
        send(0, 3);
        send(2, 3);
        drain(50);

        // every source streams single-beat packets
        for (int r = 0; r < 8; r++)
            for (int s = 0; s < N; s++) send(s, 1);
        drain(100);

        // stalled first beat from source 1, source 0 arrives a cycle later
        set_all(100, 0);
        send(1, 2);
        @(posedge clk); #3;
        send(0, 1);
        repeat (3) @(posedge clk);
        #3 rprob = 100;
        drain(50);

        // bubbling source 3 while source 0 keeps requesting
        vprob[3] = 40;
        send(3, 4);
        send(0, 2);
        drain(200);

        // reset in the middle of a packet from source 2
        set_all(100, 100);
        send(2, 4);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        for (int s = 0; s < N; s++) begin
            stim_q[s].delete();
            exp_q[s].delete();
        end
        #1;
        chk("rst_mid_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_mid_s_ready", 32'(s_ready_o), 32'd0);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        send(2, 2);
        send(0, 2);
        drain(50);

        // randomized traffic
        for (int p = 0; p < 400; p++) begin
            if (p % 40 == 0) begin
                for (int s = 0; s < N; s++) vprob[s] = $urandom_range(100, 50);
                rprob = $urandom_range(100, 30);
            end
            send($urandom_range(N - 1), $urandom_range(4, 1));
            repeat ($urandom_range(3)) @(posedge clk);
            #3;
        end
        drain(5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stream_upsize_arb.md
# stream_upsize_arb

Packet-level round-robin arbiter that shares one `stream_upsize` slave port between `N_SRC` narrow stream sources. A grant is held from a source's first presented beat until its `last` beat is accepted, so a packet is never interleaved and the upsizer's word packing and `keep` generation stay per-source. The arbiter sits directly in front of the upsizer's `s_*` port. Data passes through combinationally, with zero added latency.

## Interface
- `N_SRC`, 4, number of requesting sources, 2..16.
- `T_DATA_WIDTH`, 4, beat width; must match the downstream upsizer.
- `SRC_W`, `$clog2(N_SRC)`, source index width; localparam.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `s_data_i` input `[N_SRC-1:0][T_DATA_WIDTH-1:0]`: per-source beat data.
- `s_last_i` input `N_SRC`: per-source end-of-packet.
- `s_valid_i` input `N_SRC`: per-source valid.
- `s_ready_o` output `N_SRC`: per-source ready; at most one bit high (one-hot).
- `m_data_o` output `T_DATA_WIDTH`: data to the upsizer.
- `m_last_o` output 1: last to the upsizer.
- `m_valid_o` output 1: valid to the upsizer.
- `m_ready_i` input 1: ready from the upsizer.
- `busy_o` output 1: high while a grant is locked.
- `m_src_o` output `SRC_W`: index of the source currently driving `m`. Present only with `STREAM_UPSIZE_ARB_ID_EN`.

## Operation
- State register `{IDLE, LOCKED}`, plus `owner` (`SRC_W` bits) and `rr_last` (`SRC_W` bits).
- IDLE:
  - `sel` = first index with `s_valid_i` set, searching `rr_last+1, rr_last+2, …` with wrap modulo `N_SRC`.
  - If no source is valid: `m_valid_o`=0 and `s_ready_o`=0.
- LOCKED:
  - `sel` = `owner`; all other sources see `s_ready_o`=0.
- Datapath for both states:
  - `m_data_o`, `m_last_o` and `m_valid_o` are taken from `sel`.
  - `s_ready_o[sel]` = `m_ready_i`.
- Handshake: `acc` = `m_valid_o && m_ready_i`.
- Transitions from IDLE:
  - `acc && m_last_o`: stay IDLE; `rr_last` <= `sel`.
  - `acc && !m_last_o`: go to LOCKED; `owner` <= `sel`.
  - `m_valid_o && !m_ready_i` (stalled presentation): go to LOCKED; `owner` <= `sel`. This keeps `m_data_o` stable under backpressure even if a higher-priority source asserts valid later.
- Transitions from LOCKED:
  - `acc && m_last_o`: go to IDLE; `rr_last` <= `owner`.
  - Owner drops `s_valid_i` mid-packet (a bubble): `m_valid_o`=0 and the grant is held. There is no timeout.
- `busy_o` = (state == LOCKED).
- Single-beat packets (`last` on the first beat) never enter LOCKED when `m_ready_i` is high.

## Timing
- Zero-cycle latency: the `s`→`m` path is purely combinational.
- Grant switching: the earliest cycle in which a new source can be accepted is the cycle after the previous `last` is accepted. Back-to-back packets from different sources therefore have no idle cycle.
- Reset values (while `rst_n`=0):
  - state = IDLE, `rr_last` = `N_SRC-1`, so source 0 has first priority.
  - `owner` = 0.
  - `s_ready_o` = 0 and `m_valid_o` = 0 (both forced low).
  - `busy_o` = 0; `m_src_o` = 0.
- Reset asserted mid-packet: the packet is abandoned and no beat is accepted during reset. After release the arbiter restarts in IDLE with source 0 first. Recovering the downstream upsizer is its own reset's responsibility.
- Simultaneous request by all sources: each source gets exactly one packet per round, in the order `rr_last+1` onward.
- `rr_last` wraps: `N_SRC-1` → 0.

## Configuration
- `STREAM_UPSIZE_ARB_ID_EN`
- Defined:
  - Port `m_src_o` exists and equals `sel`, valid whenever `m_valid_o`=1; it is 0 when no source is selected.
  - The integrator uses it to tag upsized words, e.g. as a sideband through the upsizer FIFO.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
1. After reset, sources 0 and 2 each present a 3-beat packet simultaneously with `m_ready_i`=1. Required: source 0's beats on cycles 0–2 and source 2's beats on cycles 3–5; `busy_o` high on cycles 1–2 and 4–5; `s_ready_o` one-hot throughout.
2. All 4 sources continuously send single-beat packets. Required: grant order 0,1,2,3,0,… with one accept per cycle; `busy_o` stays 0.
3. Source 1 presents beat A with `m_ready_i`=0 for 3 cycles, and source 0 raises valid in cycle 1. Required: `m_data_o`=A is held stable and source 0 is not granted until source 1's `last` is accepted.
4. Source 3 packet with a 2-cycle valid bubble between beats 1 and 2, and source 0 requesting throughout. Required: `m_valid_o`=0 during the bubble, the grant stays with 3, and source 0 is granted the cycle after 3's `last`.
5. `rst_n` pulsed low mid-packet from source 2. Required: immediately `m_valid_o`=0, `s_ready_o`=0 and `busy_o`=0; after release, source 0 wins if both 0 and 2 request.
6. With `STREAM_UPSIZE_ARB_ID_EN` defined, interleaved packets from sources 1 and 3. Required: `m_src_o` equals 1 or 3 on every accepted beat of the respective packet.
